// File: rtl/fir_mac_sequencer.sv
// Purpose : control sequencer in front of ReConf_FirFilter. On each sample tick it
//           reads coefficient RAM addresses 0..NUM_TAPS-1 and drives EnMul/EnAddAcc.
//           On a host request it streams NUM_TAPS coefficients into the coeff RAM.
// Latency : first RAM read address one cycle after the tick. EnMul lags the reads by
//           one cycle and EnAddAcc lags them by two. FrameDone pulses NUM_TAPS+3 cycles
//           after the tick.
// Backpressure: the coefficient stream is valid/ready. oCoeffReady stays high until
//           NUM_TAPS words have been accepted. A tick that arrives while busy is dropped
//           and flagged on the sticky oOverrun output.
// Ports   : iClk12M/iRsn clock and async active-low reset; iEnSample600k sample tick;
//           iUpdateReq load request; iCoeffValid/iCoeffData/oCoeffReady coefficient
//           stream; oCsnRam/oWrnRam/oAddrRam/oWtDtRam coeff RAM port; oEnMul/oEnAddAcc
//           filter strobes; oCoeffUpdateFlag filter update flag; oFrameDone/oBusy/
//           oOverrun status.
module fir_mac_sequencer #(
  parameter int NUM_TAPS = 10,
  parameter int ADDR_W   = 6,
  parameter int DATA_W   = 16,
  parameter int HOLD_CYC = 2
) (
  input  logic              iClk12M,
  input  logic              iRsn,
  input  logic              iEnSample600k,
  input  logic              iUpdateReq,
  input  logic              iCoeffValid,
  input  logic [DATA_W-1:0] iCoeffData,
  output logic              oCoeffReady,
  output logic              oCoeffUpdateFlag,
  output logic              oCsnRam,
  output logic              oWrnRam,
  output logic [ADDR_W-1:0] oAddrRam,
  output logic [DATA_W-1:0] oWtDtRam,
  output logic              oEnMul,
  output logic              oEnAddAcc,
  output logic              oFrameDone,
  output logic              oBusy,
  output logic              oOverrun
);

  localparam int HOLD_W = (HOLD_CYC < 1) ? 1 : $clog2(HOLD_CYC + 1);
  localparam logic [ADDR_W-1:0] LAST_TAP  = ADDR_W'(NUM_TAPS - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYC);

  typedef enum logic [2:0] {
    IDLE,
    RD,
    DRAIN1,
    DRAIN2,
    UPD_SETUP,
    UPD_WR,
    UPD_HOLD
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] cnt;
  logic [HOLD_W-1:0] hold_cnt;
  logic              pending;
  logic              accept;

  assign accept = iCoeffValid & oCoeffReady;
  assign oBusy  = (state != IDLE);

  always_ff @(posedge iClk12M or negedge iRsn) begin
    if (!iRsn) begin
      state            <= IDLE;
      cnt              <= '0;
      hold_cnt         <= '0;
      pending          <= 1'b0;
      oCoeffReady      <= 1'b0;
      oCoeffUpdateFlag <= 1'b0;
      oCsnRam          <= 1'b1;
      oWrnRam          <= 1'b1;
      oAddrRam         <= '0;
      oWtDtRam         <= '0;
      oEnMul           <= 1'b0;
      oEnAddAcc        <= 1'b0;
      oFrameDone       <= 1'b0;
      oOverrun         <= 1'b0;
    end else begin
      oFrameDone <= 1'b0;
      // The multiplier sees RAM data one cycle after the address, and the
      // accumulator sees the product one cycle after that.
      oEnMul    <= (state == RD);
      oEnAddAcc <= oEnMul;

      if (iEnSample600k && (state != IDLE)) begin
        oOverrun <= 1'b1;
      end
      // Any request that is not started directly from IDLE goes into the
      // single-entry pending slot. Repeated requests merge into that slot.
      if (iUpdateReq && (state != IDLE)) begin
        pending <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (iEnSample600k) begin
            state    <= RD;
            cnt      <= '0;
            oCsnRam  <= 1'b0;
            oWrnRam  <= 1'b1;
            oAddrRam <= '0;
            // A tick takes priority over an update. A request arriving on the
            // same edge waits in the pending slot.
            if (iUpdateReq) begin
              pending <= 1'b1;
            end
          end else if (iUpdateReq || pending) begin
            state            <= UPD_SETUP;
            oCoeffUpdateFlag <= 1'b1;
            pending          <= 1'b0;
          end
        end

        RD: begin
          if (cnt == LAST_TAP) begin
            state    <= DRAIN1;
            oCsnRam  <= 1'b1;
            oAddrRam <= '0;
          end else begin
            cnt      <= cnt + 1'b1;
            oAddrRam <= cnt + 1'b1;
          end
        end

        // Two drain cycles let the last product pass through EnMul and EnAddAcc.
        DRAIN1: state <= DRAIN2;

        DRAIN2: begin
          state      <= IDLE;
          oFrameDone <= 1'b1;
        end

        UPD_SETUP: begin
          state       <= UPD_WR;
          cnt         <= '0;
          oCoeffReady <= 1'b1;
        end

        UPD_WR: begin
          if (accept) begin
            oCsnRam  <= 1'b0;
            oWrnRam  <= 1'b0;
            oAddrRam <= cnt;
            oWtDtRam <= iCoeffData;
            cnt      <= cnt + 1'b1;
            if (cnt == LAST_TAP) begin
              state       <= UPD_HOLD;
              oCoeffReady <= 1'b0;
              hold_cnt    <= '0;
            end
          end else begin
            // Stall cycle: no write is issued. Address and data keep their
            // previous values.
            oCsnRam <= 1'b1;
            oWrnRam <= 1'b1;
          end
        end

        UPD_HOLD: begin
          oCsnRam  <= 1'b1;
          oWrnRam  <= 1'b1;
          oAddrRam <= '0;
          oWtDtRam <= '0;
          // The first UPD_HOLD cycle is the final write cycle. The flag then
          // stays high for HOLD_CYC further cycles.
          if (hold_cnt == HOLD_LAST) begin
            state            <= IDLE;
            oCoeffUpdateFlag <= 1'b0;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fir_mac_sequencer.sv
// Purpose : directed self-checking bench for fir_mac_sequencer. It covers reset,
//           the read sequence, overrun, coefficient loads with and without
//           stalls, and tick/request arbitration.
// Ports   : none. The bench drives the DUT inputs and checks the DUT outputs
//           #1 after each rising edge.
module tb_fir_mac_sequencer;

  logic        clk;
  logic        rst_n;
  logic        tick;
  logic        req;
  logic        cvld;
  logic [15:0] cdat;
  logic        ready;
  logic        flag;
  logic        csn;
  logic        wrn;
  logic [5:0]  addr;
  logic [15:0] wtdt;
  logic        enmul;
  logic        enadd;
  logic        fdone;
  logic        busy;
  logic        ovr;

  int total  = 0;
  int passed = 0;
  int fails  = 0;
  int exp_ovr = 0;

  fir_mac_sequencer #(
    .NUM_TAPS(10),
    .ADDR_W  (6),
    .DATA_W  (16),
    .HOLD_CYC(2)
  ) dut (
    .iClk12M         (clk),
    .iRsn            (rst_n),
    .iEnSample600k   (tick),
    .iUpdateReq      (req),
    .iCoeffValid     (cvld),
    .iCoeffData      (cdat),
    .oCoeffReady     (ready),
    .oCoeffUpdateFlag(flag),
    .oCsnRam         (csn),
    .oWrnRam         (wrn),
    .oAddrRam        (addr),
    .oWtDtRam        (wtdt),
    .oEnMul          (enmul),
    .oEnAddAcc       (enadd),
    .oFrameDone      (fdone),
    .oBusy           (busy),
    .oOverrun        (ovr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Assumes the DUT entered UPD_SETUP on the preceding edge. Performs one full
  // coefficient load. When stall_after >= 0, valid drops for 3 cycles after that
  // word. When inject is set, a tick is pushed during the first stall cycle.
  task automatic upd_data(input int stall_after, input bit inject);
    chk("upd_setup_flag", 32'(flag), 1);
    chk("upd_setup_busy", 32'(busy), 1);
    chk("upd_setup_ready", 32'(ready), 0);
    cyc();
    chk("upd_wr_ready", 32'(ready), 1);
    chk("upd_wr_csn_idle", 32'(csn), 1);
    for (int i = 0; i < 10; i++) begin
      if (stall_after >= 0 && i == stall_after + 1) begin
        cvld = 1'b0;
        for (int s = 0; s < 3; s++) begin
          if (inject && s == 0) tick = 1'b1;
          cyc();
          tick = 1'b0;
          chk("stall_csn", 32'(csn), 1);
          chk("stall_wrn", 32'(wrn), 1);
          chk("stall_ready", 32'(ready), 1);
        end
        if (inject) exp_ovr = 1;
        chk("upd_overrun", 32'(ovr), 32'(exp_ovr));
      end
      cvld = 1'b1;
      cdat = 16'(32'hA00 + i);
      cyc();
      chk("wr_csn", 32'(csn), 0);
      chk("wr_wrn", 32'(wrn), 0);
      chk("wr_addr", 32'(addr), 32'(i));
      chk("wr_data", 32'(wtdt), 32'hA00 + 32'(i));
      chk("wr_enmul", 32'(enmul), 0);
      chk("wr_ready", 32'(ready), 32'(i < 9));
    end
    cvld = 1'b0;
    cdat = 16'h0;
    cyc();
    chk("post_csn", 32'(csn), 1);
    chk("post_wrn", 32'(wrn), 1);
    chk("post_addr", 32'(addr), 0);
    chk("post_data", 32'(wtdt), 0);
    chk("hold1_flag", 32'(flag), 1);
    cyc();
    chk("hold2_flag", 32'(flag), 1);
    cyc();
    chk("flag_drop", 32'(flag), 0);
    chk("upd_end_busy", 32'(busy), 0);
  endtask

  // Performs one read sequence from IDLE. It can optionally raise a request on
  // the tick edge and inject a second tick at T+5.
  task automatic run_read(input bit with_req, input bit second);
    tick = 1'b1;
    req  = with_req;
    cyc();
    tick = 1'b0;
    req  = 1'b0;
    chk("rd0_csn", 32'(csn), 0);
    chk("rd0_wrn", 32'(wrn), 1);
    chk("rd0_addr", 32'(addr), 0);
    chk("rd0_enmul", 32'(enmul), 0);
    chk("rd0_busy", 32'(busy), 1);
    chk("rd0_flag", 32'(flag), 0);
    for (int k = 1; k < 10; k++) begin
      if (second && k == 5) tick = 1'b1;
      cyc();
      tick = 1'b0;
      chk("rd_addr", 32'(addr), 32'(k));
      chk("rd_csn", 32'(csn), 0);
      chk("rd_enmul", 32'(enmul), 1);
      chk("rd_enadd", 32'(enadd), 32'(k >= 2));
      chk("rd_fdone", 32'(fdone), 0);
    end
    if (second) exp_ovr = 1;
    cyc();
    chk("rd10_csn", 32'(csn), 1);
    chk("rd10_addr", 32'(addr), 0);
    chk("rd10_enmul", 32'(enmul), 1);
    chk("rd10_enadd", 32'(enadd), 1);
    cyc();
    chk("rd11_enmul", 32'(enmul), 0);
    chk("rd11_enadd", 32'(enadd), 1);
    chk("rd11_fdone", 32'(fdone), 0);
    chk("rd11_busy", 32'(busy), 1);
    cyc();
    chk("rd12_enadd", 32'(enadd), 0);
    chk("rd12_fdone", 32'(fdone), 1);
    chk("rd12_busy", 32'(busy), 0);
    chk("rd12_overrun", 32'(ovr), 32'(exp_ovr));
  endtask

  initial begin
    rst_n = 1'b0;
    tick  = 1'b0;
    req   = 1'b0;
    cvld  = 1'b0;
    cdat  = 16'h0;
    repeat (3) cyc();
    chk("rst_csn", 32'(csn), 1);
    chk("rst_wrn", 32'(wrn), 1);
    chk("rst_addr", 32'(addr), 0);
    chk("rst_data", 32'(wtdt), 0);
    chk("rst_flag", 32'(flag), 0);
    chk("rst_enmul", 32'(enmul), 0);
    chk("rst_enadd", 32'(enadd), 0);
    chk("rst_ready", 32'(ready), 0);
    chk("rst_fdone", 32'(fdone), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_overrun", 32'(ovr), 0);
    rst_n = 1'b1;
    cyc();
    chk("idle_busy", 32'(busy), 0);

    // Read sequence, with a second tick dropped at T+5.
    run_read(1'b0, 1'b1);
    cyc();
    chk("fdone_pulse_end", 32'(fdone), 0);
    chk("overrun_sticky", 32'(ovr), 1);

    // Back-to-back coefficient load.
    req = 1'b1;
    cyc();
    req = 1'b0;
    upd_data(-1, 1'b0);

    // Reset asserted mid-read, with a request pending.
    tick = 1'b1;
    cyc();
    tick = 1'b0;
    req  = 1'b1;
    cyc();
    req  = 1'b0;
    cyc();
    rst_n = 1'b0;
    #1;
    chk("mrst_csn", 32'(csn), 1);
    chk("mrst_wrn", 32'(wrn), 1);
    chk("mrst_addr", 32'(addr), 0);
    chk("mrst_enmul", 32'(enmul), 0);
    chk("mrst_enadd", 32'(enadd), 0);
    chk("mrst_busy", 32'(busy), 0);
    chk("mrst_overrun", 32'(ovr), 0);
    exp_ovr = 0;
    cyc();
    rst_n = 1'b1;
    repeat (3) cyc();
    chk("pending_cleared_busy", 32'(busy), 0);
    chk("pending_cleared_flag", 32'(flag), 0);

    // Stalled load, with a tick dropped during the update.
    req = 1'b1;
    cyc();
    req = 1'b0;
    upd_data(4, 1'b1);

    // Tick and request on the same edge: the read runs first, then the load.
    run_read(1'b1, 1'b0);
    cyc();
    upd_data(-1, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
